counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter_if.sv | 45 ++++
 rtl/counter_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_counter_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// -----------------------------------------------------------------------------
// counter_arbiter_if
//
// Bundles the request/grant signals between N requesters and the shared
// interval counter.
//
//   req   [N-1:0]    per-requester request
//   len   [N*W-1:0]  per-requester terminal count, slice i = len[i*W +: W]
//   gnt   [N-1:0]    one-hot0 grant, bit i high while requester i owns the counter
//   busy             high while any grant is held
//   count [W-1:0]    current value of the shared counter
//   done  [N-1:0]    one-cycle completion pulse per requester
//
// master : requester side (drives req/len, observes the rest)
// slave  : arbiter side   (observes req/len, drives the rest)
// -----------------------------------------------------------------------------
interface counter_arbiter_if #(
    parameter int N = 4,
    parameter int W = 10
);
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;

    modport master (
        output req,
        output len,
        input  gnt,
        input  busy,
        input  count,
        input  done
    );

    modport slave (
        input  req,
        input  len,
        output gnt,
        output busy,
        output count,
        output done
    );
endinterface

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//
// N requesters share a single W-bit interval counter. While idle, the arbiter
// picks the first requester at or above a round-robin pointer, latches that
// requester's terminal count and runs the counter from 0 up to it. When the
// terminal count is reached the grant drops, the owner gets a one-cycle done
// pulse and the pointer moves past the owner. Arbitration is non-preemptive:
// once a grant is issued, req/len changes have no effect until it completes.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   counter_arbiter_if.slave (req, len in; gnt, busy, count, done out)
//
// Every output is driven straight from a flop, so there is no combinational
// path from req or len to any output.
// -----------------------------------------------------------------------------
module counter_arbiter #(
    parameter int N = 4,
    parameter int W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_arbiter_if.slave     bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_nxt;
    logic [W-1:0]    term;
    logic [W-1:0]    term_nxt;
    logic [W-1:0]    count;
    logic [W-1:0]    count_nxt;
    logic [N-1:0]    gnt;
    logic [N-1:0]    gnt_nxt;
    logic [N-1:0]    done;
    logic [N-1:0]    done_nxt;
    logic            busy;

    logic            found;
    logic [PW-1:0]   winner;
    logic            last;

    // -------------------------------------------------------------------------
    // Cyclic priority search: returns {found, index} of the first set bit of r
    // at or above p, wrapping past N-1 back to 0. Walking k downwards lets the
    // smallest cyclic distance overwrite any farther candidate.
    // -------------------------------------------------------------------------
    function automatic logic [PW:0] pick_winner(input logic [N-1:0]  r,
                                                input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (r[idx]) begin
                res = {1'b1, idx[PW-1:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [PW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // (i + 1) mod N, valid for any N, not only powers of two
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        logic [PW-1:0] r;
        if (int'(i) == N - 1) begin
            r = '0;
        end else begin
            r = i + 1'b1;
        end
        return r;
    endfunction

    assign {found, winner} = pick_winner(bus.req, ptr);

    // Terminal count reached: this is the final cycle of the grant. Because
    // the run ends here, count can never step past term and never wraps,
    // even for term = all-ones.
    assign last = (count == term);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values. The IDLE cycle that carries done also
    // arbitrates, so a waiting requester is granted one cycle after done.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_nxt   = gnt;
        count_nxt = count;
        term_nxt  = term;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        done_nxt  = '0;
        unique case (state)
            IDLE: begin
                gnt_nxt   = '0;
                count_nxt = '0;
                if (found) begin
                    gnt_nxt   = to_onehot(winner);
                    owner_nxt = winner;
                    term_nxt  = bus.len[int'(winner) * W +: W];
                end
            end
            RUN: begin
                if (last) begin
                    gnt_nxt   = '0;
                    count_nxt = '0;
                    done_nxt  = to_onehot(owner);
                    ptr_nxt   = wrap_inc(owner);
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = '0;
                count_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath registers. Reset aborts any run without a done pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            done  <= '0;
            count <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            term  <= '0;
            owner <= '0;
        end else begin
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            count <= count_nxt;
            busy  <= |gnt_nxt;
            ptr   <= ptr_nxt;
            term  <= term_nxt;
            owner <= owner_nxt;
        end
    end

    assign bus.gnt   = gnt;
    assign bus.busy  = busy;
    assign bus.count = count;
    assign bus.done  = done;

endmodule

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
//
// Directed scenarios followed by randomized traffic against a behavioural
// reference of the counter arbiter (owner + remaining-cycle countdown).
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_arbiter_if #(.N(N), .W(W)) bus ();

    counter_arbiter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    int           m_owner;   // -1 when idle
    int           m_rem;     // grant cycles still to go after the current one
    int           m_term;
    int           m_ptr;
    logic [N-1:0] m_done;

    logic [N-1:0] exp_gnt;
    logic [W-1:0] exp_count;
    logic         exp_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] ln);
        m_done = '0;
        if (r) begin
            m_owner = -1;
            m_rem   = 0;
            m_term  = 0;
            m_ptr   = 0;
        end else if (m_owner >= 0) begin
            if (m_rem == 0) begin
                m_done[m_owner] = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_rem = m_rem - 1;
            end
        end else if (rq != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (rq[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_term = int'(ln[m_owner * W +: W]);
            m_rem  = m_term;
        end
        exp_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        exp_busy  = (m_owner >= 0);
        exp_count = (m_owner >= 0) ? W'(m_term - m_rem) : '0;
    endtask

    // one clock: model follows the inputs present at the edge, outputs compared after it
    task automatic step();
        @(posedge clk);
        model_step(rst, bus.req, bus.len);
        #1;
        check("gnt",   32'(bus.gnt),   32'(exp_gnt));
        check("busy",  32'(bus.busy),  32'(exp_busy));
        check("count", 32'(bus.count), 32'(exp_count));
        check("done",  32'(bus.done),  32'(m_done));
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i * W +: W] = W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.req = '0;
        for (int i = 0; i < 40; i++) begin
            if (m_owner < 0 && m_done == '0) break;
            step();
        end
        check("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int glen;
        logic [N-1:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst     = 1'b1;
        bus.req = '0;
        bus.len = '0;
        m_owner = -1; m_rem = 0; m_term = 0; m_ptr = 0; m_done = '0;

        // reset state
        step();
        step();
        check("rst_gnt",   32'(bus.gnt),   32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        rst = 1'b0;

        // single request, len0 = 3
        bus.req = 4'b0001;
        set_len(0, 3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_gnt", 32'(bus.gnt),   32'h1);
            check("single_cnt", 32'(bus.count), 32'(i));
            if (i == 0) bus.req = '0;
        end
        step();
        check("single_done", 32'(bus.done), 32'h1);
        check("single_off",  32'(bus.gnt),  32'h0);
        step();
        check("single_idle", 32'(bus.done), 32'h0);

        // round robin, all len = 0, starting from reset pointer
        do_reset();
        bus.req = 4'b1111;
        bus.len = '0;
        for (int g = 0; g < 5; g++) begin
            step();
            check("rr_gnt", 32'(bus.gnt), 32'(rr_exp[g]));
            if (g == 4) bus.req = '0;
            step();
            check("rr_done", 32'(bus.done), 32'(rr_exp[g]));
        end
        drain();

        // pointer rotation: grant 2, then 0101 selects 0
        do_reset();
        bus.req = 4'b0100;
        step();
        check("rot_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0101;
        step();
        check("rot_done2", 32'(bus.done), 32'h4);
        step();
        check("rot_gnt0", 32'(bus.gnt), 32'h1);
        drain();

        // non-preemption: len1 = 5, change len and drop req at count 2
        bus.req = 4'b0010;
        set_len(1, 5);
        glen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.gnt == 4'b0010) glen++;
            if (bus.count == 2 && bus.gnt == 4'b0010) begin
                set_len(1, 1);
                bus.req = '0;
            end
            if (bus.done != '0) break;
        end
        check("np_len",  32'(glen),     32'd6);
        check("np_done", 32'(bus.done), 32'h2);
        drain();

        // reset mid-run at count 4
        bus.req = 4'b0010;
        set_len(1, 9);
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.count == 4) break;
        end
        check("mr_cnt4", 32'(bus.count), 32'd4);
        rst = 1'b1;
        step();
        check("mr_gnt",  32'(bus.gnt),   32'd0);
        check("mr_cnt",  32'(bus.count), 32'd0);
        check("mr_done", 32'(bus.done),  32'd0);
        rst = 1'b0;
        step();
        check("mr_regnt", 32'(bus.gnt), 32'h2);
        drain();

        // boundary: all-ones terminal count
        bus.req = 4'b0001;
        set_len(0, 15);
        glen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.gnt == 4'b0001) begin
                check("bnd_cnt", 32'(bus.count), 32'(glen));
                glen++;
                bus.req = '0;
            end
            if (bus.done != '0) break;
        end
        check("bnd_len",  32'(glen),     32'd16);
        check("bnd_done", 32'(bus.done), 32'h1);
        drain();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            bus.req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 5))
                    0:       set_len(j, 0);
                    1:       set_len(j, (1 << W) - 1);
                    default: set_len(j, int'($urandom_range(0, 6)));
                endcase
            end
            step();
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
